// File: rtl/multicycle_controller.sv
// multicycle_controller: multi-cycle CPU control FSM with memory-handshake stalls and illegal-op trap.
// Optional MC_PERF_CNT_EN adds a 32-bit retired-instruction counter on instret.
module multicycle_controller #(
  parameter logic [4:0] RA_REG  = 5'd31,
  parameter bit         TRAP_ON = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        reg_we,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wb_sel,
  output logic        alu_src,
  output logic [2:0]  alu_op,
  output logic        dm_we,
  output logic        mem_req,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] instret
);
  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                         S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd7;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BNE = 6'h05,
                         OP_ADDI = 6'h08, OP_XORI = 6'h0E, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_JR = 6'h08, FN_ADD = 6'h20, FN_SUB = 6'h22, FN_SLT = 6'h2A;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_XOR = 3'd2, ALU_SLT = 3'd3;
  logic [2:0] state_q, state_d, bad_st;
  logic ir_we_c, pc_we_c, reg_we_c, dm_we_c, retire, is_r_ok, is_op_ok;
  logic unused_ra;
  assign unused_ra = ^RA_REG;
  assign is_r_ok  = funct inside {FN_ADD, FN_SUB, FN_SLT};
  assign is_op_ok = opcode inside {OP_R, OP_BNE, OP_ADDI, OP_XORI, OP_LW, OP_SW};
  // Illegal encodings either park in TRAP or are silently dropped as a NOP.
  assign bad_st   = TRAP_ON ? S_TRAP : S_FETCH;
  always_comb begin
    state_d  = state_q;
    ir_we_c  = 1'b0;
    pc_we_c  = 1'b0;
    reg_we_c = 1'b0;
    dm_we_c  = 1'b0;
    retire   = 1'b0;
    pc_src   = 2'b00;
    reg_dst  = 2'b00;
    wb_sel   = 2'b00;
    alu_src  = 1'b0;
    alu_op   = ALU_ADD;
    mem_req  = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (opcode == OP_J || opcode == OP_JAL) begin
          pc_we_c  = 1'b1;
          pc_src   = 2'b10;
          reg_we_c = opcode == OP_JAL;
          reg_dst  = opcode == OP_JAL ? 2'b10 : 2'b00;
          wb_sel   = opcode == OP_JAL ? 2'b10 : 2'b00;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else
          state_d = is_op_ok ? S_EXEC : bad_st;
      end
      S_EXEC: begin
        case (opcode)
          OP_R: begin
            alu_op = funct == FN_SUB ? ALU_SUB : funct == FN_SLT ? ALU_SLT : ALU_ADD;
            if (funct == FN_JR) begin
              pc_we_c = 1'b1;
              pc_src  = 2'b11;
              retire  = 1'b1;
              state_d = S_FETCH;
            end else
              state_d = is_r_ok ? S_WB : bad_st;
          end
          OP_ADDI: begin
            alu_src = 1'b1;
            state_d = S_WB;
          end
          OP_XORI: begin
            alu_src = 1'b1;
            alu_op  = ALU_XOR;
            state_d = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_src = 1'b1;
            state_d = S_MEM;
          end
          OP_BNE: begin
            alu_op  = ALU_SUB;
            pc_src  = 2'b01;
            pc_we_c = ~zero;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = bad_st;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        alu_src = 1'b1;
        if (mem_ready) begin
          dm_we_c = opcode == OP_SW;
          retire  = opcode == OP_SW;
          state_d = opcode == OP_SW ? S_FETCH : S_WB;
        end
      end
      S_WB: begin
        reg_we_c = 1'b1;
        reg_dst  = opcode == OP_R ? 2'b01 : 2'b00;
        wb_sel   = opcode == OP_LW ? 2'b01 : 2'b00;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= S_FETCH;
    else state_q <= state_d;
  // Gating with reset aborts a pending write in the same cycle reset rises.
  assign ir_we   = ir_we_c & ~reset;
  assign pc_we   = pc_we_c & ~reset;
  assign reg_we  = reg_we_c & ~reset;
  assign dm_we   = dm_we_c & ~reset;
  assign state   = state_q;
  assign illegal = state_q == S_TRAP;
`ifdef MC_PERF_CNT_EN
  logic [31:0] instret_q, instret_d;
  assign instret_d = instret_q + {31'd0, retire};
  always_ff @(posedge clk or posedge reset)
    if (reset) instret_q <= 32'd0;
    else instret_q <= instret_d;
  assign instret = instret_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign instret = 32'h0;
`endif
endmodule
